// File: rtl/bool2_b_if.sv
// Signal bundle for bool2_b: three Boolean operands in; the combinational result,
// its registered copy, edge pulses and the high-cycle count out.
interface bool2_b_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             b;
    logic             c;
    logic             e;
    logic             e_q;
    logic             e_rise;
    logic             e_fall;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output a, b, c,
        input  e, e_q, e_rise, e_fall, hi_cnt
    );

    modport slave (
        input  a, b, c,
        output e, e_q, e_rise, e_fall, hi_cnt
    );
endinterface

// File: rtl/bool2_b.sv
// 3-input lookup-table function with a registered copy, rise/fall pulse detection
// and a saturating counter of cycles in which the registered result is high.
module bool2_b #(
    parameter logic [7:0] TRUTH_TABLE = 8'hB8,
    parameter int         CNT_W       = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    bool2_b_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       idx_s;
    logic             e_s;

    logic             eq_d,      eq_q;
    logic             eq_prev_d, eq_prev_q;
    logic             rise_d,    rise_q;
    logic             fall_d,    fall_q;
    logic [CNT_W-1:0] cnt_d,     cnt_q;

    // The result stays live during reset; X/Z inputs fall through the table index unresolved.
    assign idx_s = {bus.a, bus.b, bus.c};
    assign e_s   = TRUTH_TABLE[idx_s];

    // Next-state: pipeline the result, derive edge pulses from the previous two samples.
    always_comb begin
        eq_d      = e_s;
        eq_prev_d = eq_q;
        rise_d    = eq_q & ~eq_prev_q;
        fall_d    = ~eq_q & eq_prev_q;
        cnt_d     = cnt_q;
        if (eq_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset clears everything immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q      <= 1'b0;
            eq_prev_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            eq_q      <= eq_d;
            eq_prev_q <= eq_prev_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.e      = e_s;
    assign bus.e_q    = eq_q;
    assign bus.e_rise = rise_q;
    assign bus.e_fall = fall_q;
    assign bus.hi_cnt = cnt_q;

endmodule

// File: tb/tb_bool2_b.sv
// Randomized and directed bench for bool2_b: default table, 4-bit saturating counter
// variant and 3-input XOR table variant, all checked against a history-based model.
module tb_bool2_b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_v = 3'b000;

    int n_vec = 0;
    int n_err = 0;

    // Model: e_q value loaded at each edge since reset, and count of high e_q cycles.
    bit hist[$];
    int ones;

    bool2_b_if #(.CNT_W(16)) if_main ();
    bool2_b_if #(.CNT_W(4))  if_sat  ();
    bool2_b_if #(.CNT_W(16)) if_xor  ();

    bool2_b #(.TRUTH_TABLE(8'hB8), .CNT_W(16)) u_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
    bool2_b #(.TRUTH_TABLE(8'hB8), .CNT_W(4))  u_sat  (.clk(clk), .rst_n(rst_n), .bus(if_sat));
    bool2_b #(.TRUTH_TABLE(8'h96), .CNT_W(16)) u_xor  (.clk(clk), .rst_n(rst_n), .bus(if_xor));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_e(input logic [2:0] v);
        return v[1] ? v[0] : v[2];
    endfunction

    task automatic drive(input logic [2:0] v);
        in_v = v;
        if_main.a = v[2]; if_main.b = v[1]; if_main.c = v[0];
        if_sat.a  = v[2]; if_sat.b  = v[1]; if_sat.c  = v[0];
        if_xor.a  = v[2]; if_xor.b  = v[1]; if_xor.c  = v[0];
    endtask

    task automatic model_clear();
        hist = {1'b0, 1'b0, 1'b0};
        ones = 0;
    endtask

    task automatic check_comb();
        check_val("e",     32'(if_main.e), 32'(ref_e(in_v)));
        check_val("e_sat", 32'(if_sat.e),  32'(ref_e(in_v)));
        check_val("e_xor", 32'(if_xor.e),  32'(^in_v));
    endtask

    task automatic check_regs();
        int  n;
        bit  q, p1, p2;
        int  exp_sat;
        n  = hist.size();
        q  = hist[n-1];
        p1 = hist[n-2];
        p2 = hist[n-3];
        exp_sat = (ones > 15) ? 15 : ones;
        check_val("e_q",      32'(if_main.e_q),    32'(q));
        check_val("e_rise",   32'(if_main.e_rise), 32'(p1 & ~p2));
        check_val("e_fall",   32'(if_main.e_fall), 32'(~p1 & p2));
        check_val("pulse_ex", 32'(if_main.e_rise & if_main.e_fall), 32'd0);
        check_val("hi_cnt",   32'(if_main.hi_cnt), 32'(ones));
        check_val("hi_sat",   32'(if_sat.hi_cnt),  32'(exp_sat));
    endtask

    // One clock: apply inputs after negedge, check e, take the edge, check registers.
    task automatic cycle(input logic [2:0] v);
        drive(v);
        #1 check_comb();
        @(posedge clk);
        if (rst_n) begin
            if (hist[hist.size()-1]) ones++;
            hist.push_back(ref_e(in_v));
        end
        #1 check_regs();
        @(negedge clk);
    endtask

    // Assert reset between edges, check immediate clear and live e, release on a negedge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_val("rst_e_q",  32'(if_main.e_q),    32'd0);
        check_val("rst_rise", 32'(if_main.e_rise), 32'd0);
        check_val("rst_fall", 32'(if_main.e_fall), 32'd0);
        check_val("rst_cnt",  32'(if_main.hi_cnt), 32'd0);
        check_val("rst_sat",  32'(if_sat.hi_cnt),  32'd0);
        drive(3'b110);
        #1 check_comb();
        drive(3'b100);
        #1 check_comb();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        drive(3'b000);
        @(negedge clk);
        cycle(3'b011);
        cycle(3'b100);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) cycle(3'(i));
        for (int i = 7; i >= 0; i--) cycle(3'(i));

        cycle(3'b000); cycle(3'b000);
        cycle(3'b100); cycle(3'b100); cycle(3'b100);

        cycle(3'b111); cycle(3'b111); cycle(3'b111);
        cycle(3'b110); cycle(3'b110); cycle(3'b110);

        async_reset();
        for (int i = 0; i < 11; i++) cycle(3'b101);
        check_val("cnt_10", 32'(if_main.hi_cnt), 32'd10);
        for (int i = 0; i < 10; i++) cycle(3'b101);
        check_val("sat_15", 32'(if_sat.hi_cnt), 32'd15);
        cycle(3'b101); cycle(3'b101);
        check_val("sat_hold", 32'(if_sat.hi_cnt), 32'd15);

        async_reset();
        for (int i = 0; i < 8; i++) cycle(3'b101);
        check_val("pre_rst_cnt", 32'(if_main.hi_cnt), 32'd7);
        check_val("pre_rst_eq",  32'(if_main.e_q),    32'd1);
        async_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) async_reset();
            else cycle(3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
